// File: rtl/ldl_reg_count_mc.sv
// Multi-channel accumulator bank: one add/sub update, one channel clear and one registered read per cycle.
// Updates land 1 cycle after the request edge; there is no backpressure, every request is accepted or ignored.
module ldl_reg_count_mc #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SAT   = 0,
  localparam int CW   = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_vld,
  input  logic [CW-1:0]    in_ch,
  input  logic             in_dn,
  input  logic [WIDTH-1:0] in_x,
  input  logic             ch_clr,
  input  logic [CW-1:0]    ch_clr_sel,
  input  logic [WIDTH-1:0] thr,
  input  logic             rd_en,
  input  logic [CW-1:0]    rd_ch,
  output logic             rd_vld,
  output logic [WIDTH-1:0] rd_data,
  output logic [NCH-1:0]   ovf,
  output logic [NCH-1:0]   hit
);

  localparam logic [CW:0] NCH_W = (CW+1)'(NCH);

  logic [WIDTH-1:0] acc     [NCH];
  logic [WIDTH-1:0] acc_nxt [NCH];
  logic [NCH-1:0]   ovf_nxt;
  logic [NCH-1:0]   hit_nxt;
  logic             in_ok;
  logic             rd_ok;
  logic [CW-1:0]    upd_ch;
  logic [CW-1:0]    rd_idx;
  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] res;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   dif;
  logic             flow;

  // Single shared adder: only one channel can be updated per cycle.
  always_comb begin
    in_ok  = in_vld && ({1'b0, in_ch} < NCH_W);
    rd_ok  = {1'b0, rd_ch} < NCH_W;
    upd_ch = in_ok ? in_ch : '0;
    rd_idx = rd_ok ? rd_ch : '0;
    cur    = acc[upd_ch];
    sum    = {1'b0, cur} + {1'b0, in_x};
    dif    = {1'b0, cur} - {1'b0, in_x};
    flow   = in_dn ? dif[WIDTH] : sum[WIDTH];
    if (flow && (SAT != 0)) begin
      res = in_dn ? '0 : '1;
    end else begin
      res = in_dn ? dif[WIDTH-1:0] : sum[WIDTH-1:0];
    end
  end

  // Priority: global clear, then channel clear, then update.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      acc_nxt[c] = acc[c];
      ovf_nxt[c] = ovf[c];
      hit_nxt[c] = 1'b0;
      if (clr) begin
        acc_nxt[c] = '0;
        ovf_nxt[c] = 1'b0;
      end else if (ch_clr && (ch_clr_sel == CW'(c))) begin
        acc_nxt[c] = '0;
        ovf_nxt[c] = 1'b0;
      end else if (in_ok && (in_ch == CW'(c))) begin
        acc_nxt[c] = res;
        if (flow) ovf_nxt[c] = 1'b1;
        hit_nxt[c] = (cur < thr) && (res >= thr);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) acc[c] <= '0;
      ovf     <= '0;
      hit     <= '0;
      rd_vld  <= 1'b0;
      rd_data <= '0;
    end else begin
      acc    <= acc_nxt;
      ovf    <= ovf_nxt;
      hit    <= hit_nxt;
      rd_vld <= rd_en;
      // Read samples the pre-update value; out-of-range channels read as zero.
      if (rd_en) rd_data <= rd_ok ? acc[rd_idx] : '0;
    end
  end

endmodule

// File: tb/tb_ldl_reg_count_mc.sv
// Directed bench for ldl_reg_count_mc: wrap build, saturate build and a 3-channel build share one stimulus bus.
module tb_ldl_reg_count_mc;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0, in_vld = 1'b0, in_dn = 1'b0, ch_clr = 1'b0, rd_en = 1'b0;
  logic [1:0] in_ch = '0, ch_clr_sel = '0, rd_ch = '0;
  logic [7:0] in_x = '0, thr = '0;

  logic       a_vld, s_vld, t_vld;
  logic [7:0] a_data, s_data, t_data;
  logic [3:0] a_ovf, a_hit, s_ovf, s_hit;
  logic [2:0] t_ovf, t_hit;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ldl_reg_count_mc #(.WIDTH(8), .NCH(4), .SAT(0)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_vld(in_vld), .in_ch(in_ch), .in_dn(in_dn),
    .in_x(in_x), .ch_clr(ch_clr), .ch_clr_sel(ch_clr_sel), .thr(thr), .rd_en(rd_en),
    .rd_ch(rd_ch), .rd_vld(a_vld), .rd_data(a_data), .ovf(a_ovf), .hit(a_hit));

  ldl_reg_count_mc #(.WIDTH(8), .NCH(4), .SAT(1)) dut_sat (
    .clk(clk), .rst(rst), .clr(clr), .in_vld(in_vld), .in_ch(in_ch), .in_dn(in_dn),
    .in_x(in_x), .ch_clr(ch_clr), .ch_clr_sel(ch_clr_sel), .thr(thr), .rd_en(rd_en),
    .rd_ch(rd_ch), .rd_vld(s_vld), .rd_data(s_data), .ovf(s_ovf), .hit(s_hit));

  ldl_reg_count_mc #(.WIDTH(8), .NCH(3), .SAT(0)) dut3 (
    .clk(clk), .rst(rst), .clr(clr), .in_vld(in_vld), .in_ch(in_ch), .in_dn(in_dn),
    .in_x(in_x), .ch_clr(ch_clr), .ch_clr_sel(ch_clr_sel), .thr(thr), .rd_en(rd_en),
    .rd_ch(rd_ch), .rd_vld(t_vld), .rd_data(t_data), .ovf(t_ovf), .hit(t_hit));

  typedef struct {
    logic       c;
    logic       v;
    logic [1:0] ch;
    logic       dn;
    logic [7:0] x;
    logic       cc;
    logic [1:0] ccs;
    logic [7:0] th;
    logic       rd;
    logic [1:0] rch;
    logic       e_vld;
    logic [7:0] e_data;
    logic [3:0] e_ovf;
    logic [3:0] e_hit;
  } vec_t;

  function automatic vec_t mk(input logic c, input logic v, input logic [1:0] ch, input logic dn,
                              input logic [7:0] x, input logic cc, input logic [1:0] ccs,
                              input logic [7:0] th, input logic rd, input logic [1:0] rch,
                              input logic e_vld, input logic [7:0] e_data,
                              input logic [3:0] e_ovf, input logic [3:0] e_hit);
    vec_t r;
    r.c = c; r.v = v; r.ch = ch; r.dn = dn; r.x = x; r.cc = cc; r.ccs = ccs; r.th = th;
    r.rd = rd; r.rch = rch; r.e_vld = e_vld; r.e_data = e_data; r.e_ovf = e_ovf; r.e_hit = e_hit;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Drive on the falling edge, return 1 time unit after the next rising edge.
  task automatic step(input logic c, input logic v, input logic [1:0] ch, input logic dn,
                      input logic [7:0] x, input logic cc, input logic [1:0] ccs,
                      input logic [7:0] th, input logic rd, input logic [1:0] rch);
    @(negedge clk);
    clr = c; in_vld = v; in_ch = ch; in_dn = dn; in_x = x;
    ch_clr = cc; ch_clr_sel = ccs; thr = th; rd_en = rd; rd_ch = rch;
    @(posedge clk);
    #1;
  endtask

  vec_t tv[$];

  initial begin
    // clr v  ch dn x    cc ccs thr rd rch | vld data ovf hit
    tv.push_back(mk(0,1,1,0,200, 0,0,  0, 0,0,  0,  0,4'b0000,4'b0000));
    tv.push_back(mk(0,1,1,0,100, 0,0,  0, 0,0,  0,  0,4'b0010,4'b0000));
    tv.push_back(mk(0,0,0,0,  0, 0,0,  0, 1,1,  1, 44,4'b0010,4'b0000));
    tv.push_back(mk(0,0,0,0,  0, 0,0,  0, 1,0,  1,  0,4'b0010,4'b0000));
    tv.push_back(mk(0,0,0,0,  0, 0,0,  0, 1,2,  1,  0,4'b0010,4'b0000));
    tv.push_back(mk(0,0,0,0,  0, 0,0,  0, 1,3,  1,  0,4'b0010,4'b0000));
    tv.push_back(mk(0,1,0,0, 90, 0,0,100, 0,0,  0,  0,4'b0010,4'b0000));
    tv.push_back(mk(0,1,0,0, 15, 0,0,100, 0,0,  0,  0,4'b0010,4'b0001));
    tv.push_back(mk(0,1,0,0,  5, 0,0,100, 1,0,  1,105,4'b0010,4'b0000));
    tv.push_back(mk(0,1,0,1, 20, 0,0,100, 0,0,  0,105,4'b0010,4'b0000));
    tv.push_back(mk(0,1,0,0, 20, 0,0,100, 0,0,  0,105,4'b0010,4'b0001));
    tv.push_back(mk(0,0,0,0,  0, 0,0,100, 0,0,  0,105,4'b0010,4'b0000));
    tv.push_back(mk(0,1,2,0,250, 0,0,100, 0,0,  0,105,4'b0010,4'b0100));
    tv.push_back(mk(0,1,2,0, 10, 0,0,100, 0,0,  0,105,4'b0110,4'b0000));
    tv.push_back(mk(0,1,3,0,  5, 0,0,  0, 0,0,  0,105,4'b0110,4'b0000));
    tv.push_back(mk(0,1,3,0,  7, 1,3,  0, 0,0,  0,105,4'b0110,4'b0000));
    tv.push_back(mk(0,0,0,0,  0, 0,0,  0, 1,3,  1,  0,4'b0110,4'b0000));
    tv.push_back(mk(0,1,0,0,  7, 1,1,  0, 1,1,  1, 44,4'b0100,4'b0000));
    tv.push_back(mk(0,0,0,0,  0, 0,0,  0, 1,1,  1,  0,4'b0100,4'b0000));
    tv.push_back(mk(0,0,0,0,  0, 0,0,  0, 1,0,  1,117,4'b0100,4'b0000));
    tv.push_back(mk(1,1,3,0,150, 0,0,100, 0,0,  0,117,4'b0000,4'b0000));
    tv.push_back(mk(0,0,0,0,  0, 0,0,  0, 1,0,  1,  0,4'b0000,4'b0000));
    tv.push_back(mk(0,0,0,0,  0, 0,0,  0, 1,2,  1,  0,4'b0000,4'b0000));
    tv.push_back(mk(0,1,1,0,  5, 0,0,  0, 0,0,  0,  0,4'b0000,4'b0000));
    tv.push_back(mk(0,1,1,0,  3, 0,0,  0, 1,1,  1,  5,4'b0000,4'b0000));
    tv.push_back(mk(0,0,0,0,  0, 0,0,  0, 1,1,  1,  8,4'b0000,4'b0000));
    tv.push_back(mk(0,0,0,0,  0, 0,0,  0, 0,0,  0,  8,4'b0000,4'b0000));
    tv.push_back(mk(0,1,3,1, 10, 0,0,  0, 0,0,  0,  8,4'b1000,4'b0000));
    tv.push_back(mk(0,0,0,0,  0, 0,0,  0, 1,3,  1,246,4'b1000,4'b0000));
    tv.push_back(mk(0,1,2,0,  0, 0,0,  1, 0,0,  0,246,4'b1000,4'b0000));
    tv.push_back(mk(0,0,0,0,  0, 0,0,  1, 1,2,  1,  0,4'b1000,4'b0000));

    // Power-on reset state.
    #12;
    chk("por rd_vld", a_vld, 0);
    chk("por rd_data", a_data, 0);
    chk("por ovf", a_ovf, 0);
    chk("por hit", a_hit, 0);
    @(negedge clk);
    rst = 1'b0;

    // Dirty some state, then reset asynchronously mid-stream.
    step(0,1,1,0,50, 0,0,0, 0,0);
    step(0,1,0,1, 1, 0,0,0, 1,1);
    chk("pre-rst rd_data", a_data, 50);
    chk("pre-rst ovf", a_ovf, 4'b0001);
    @(negedge clk);
    in_vld = 1'b1; in_ch = 2'd1; in_dn = 1'b0; in_x = 8'd9; rd_en = 1'b1; rd_ch = 2'd1;
    #2 rst = 1'b1;
    #1;
    chk("rst rd_vld", a_vld, 0);
    chk("rst rd_data", a_data, 0);
    chk("rst ovf", a_ovf, 0);
    @(posedge clk);
    #1;
    chk("rst hold rd_vld", a_vld, 0);
    chk("rst hold rd_data", a_data, 0);
    chk("rst hold ovf", a_ovf, 0);
    chk("rst hold hit", a_hit, 0);
    @(negedge clk);
    rst = 1'b0; in_vld = 1'b0; rd_en = 1'b0;

    // Table-driven pass on the wrap build.
    for (int i = 0; i < tv.size(); i++) begin
      step(tv[i].c, tv[i].v, tv[i].ch, tv[i].dn, tv[i].x, tv[i].cc, tv[i].ccs,
           tv[i].th, tv[i].rd, tv[i].rch);
      chk($sformatf("v%0d rd_vld", i), a_vld, tv[i].e_vld);
      chk($sformatf("v%0d rd_data", i), a_data, tv[i].e_data);
      chk($sformatf("v%0d ovf", i), a_ovf, tv[i].e_ovf);
      chk($sformatf("v%0d hit", i), a_hit, tv[i].e_hit);
    end

    // Saturating build.
    step(1,0,0,0, 0, 0,0,0, 0,0);
    step(0,1,2,0,10, 0,0,0, 0,0);
    step(0,1,2,1,30, 0,0,0, 0,0);
    step(0,0,0,0, 0, 0,0,0, 1,2);
    chk("sat floor data", s_data, 0);
    chk("sat floor ovf", s_ovf, 4'b0100);
    step(0,1,2,0,250, 0,0,0, 0,0);
    step(0,1,2,0,10, 0,0,0, 1,2);
    chk("sat pre data", s_data, 250);
    step(0,0,0,0, 0, 0,0,0, 1,2);
    chk("sat ceil data", s_data, 255);
    chk("sat ceil ovf", s_ovf, 4'b0100);

    // Three-channel build: index 3 is out of range.
    step(1,0,0,0, 0, 0,0,0, 0,0);
    step(0,1,2,0, 9, 0,0,0, 0,0);
    step(0,1,3,1, 5, 0,0,0, 0,0);
    chk("nch3 ovf", {29'd0, t_ovf}, 0);
    step(0,0,0,0, 0, 0,0,0, 1,3);
    chk("nch3 oob rd_vld", t_vld, 1);
    chk("nch3 oob rd_data", t_data, 0);
    step(0,0,0,0, 0, 1,3,0, 1,2);
    chk("nch3 ch2 data", t_data, 9);
    step(0,0,0,0, 0, 0,0,0, 1,2);
    chk("nch3 ch2 after oob clr", t_data, 9);
    step(0,0,0,0, 0, 0,0,0, 1,0);
    chk("nch3 ch0 data", t_data, 0);
    chk("nch3 hit", {29'd0, t_hit}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
